// File: rtl/pipe_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipe_pkg : shared types and constants for elastic pipeline stage registers
// Revision : 1.0
// ----------------------------------------------------------------------------
package pipe_pkg;

    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_occ_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    localparam int          IF_ID_W      = $bits(if_id_t);
    localparam logic [63:0] IF_ID_BUBBLE = {32'h0000_0000, RV_NOP};

    function automatic logic [1:0] occ_count(input pipe_occ_e s);
        logic [1:0] n;
        n = 2'd0;
        case (s)
            ONE:     n = 2'd1;
            FULL:    n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stage_skid_reg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipe_stage_skid_reg : valid/ready pipeline register with 2-entry skid buffer
// Revision : 1.0
// ----------------------------------------------------------------------------
module pipe_stage_skid_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W     = IF_ID_W,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = IF_ID_BUBBLE,
    parameter bit                FLUSH_WINS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    pipe_occ_e         state_q, state_d;
    logic [DATA_W-1:0] main_q,  main_d;
    logic [DATA_W-1:0] skid_q,  skid_d;

    logic in_fire;
    logic out_fire;

    // in_ready depends only on held state (and reset), never on out_ready
    assign in_ready  = (state_q != FULL) & rst;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign occupancy = occ_count(state_q);

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (flush) begin
            skid_d = BUBBLE_VAL;
            if (!FLUSH_WINS && in_fire) begin
                main_d  = in_data;
                state_d = ONE;
            end else begin
                main_d  = BUBBLE_VAL;
                state_d = EMPTY;
            end
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        skid_d  = in_data;
                        state_d = FULL;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= EMPTY;
            main_q  <= BUBBLE_VAL;
            skid_q  <= BUBBLE_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid_reg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pipe_stage_skid_reg : directed checks of two stage instances (FLUSH_WINS=1/0)
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_pipe_stage_skid_reg;

    localparam logic [63:0] BUB = 64'h0000_0000_0000_0013;
    localparam logic [63:0] A   = 64'h0000_0004_0000_0093;
    localparam logic [63:0] B   = 64'h0000_0008_0010_0113;
    localparam logic [63:0] C   = 64'h0000_000C_0020_0193;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [63:0] in_data;
    logic        out_ready;

    logic        in_ready0, out_valid0, in_ready1, out_valid1;
    logic [63:0] out_data0, out_data1;
    logic [1:0]  occ0, occ1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_stage_skid_reg #(.DATA_W(64), .BUBBLE_VAL(BUB), .FLUSH_WINS(1'b1)) u_dut_fw1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .occupancy(occ0)
    );

    pipe_stage_skid_reg #(.DATA_W(64), .BUBBLE_VAL(BUB), .FLUSH_WINS(1'b0)) u_dut_fw0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .occupancy(occ1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = A; out_ready = 1'b1;
        step();
        step();
        chk("rst_in_ready",  64'(in_ready0),  64'd0);
        chk("rst_out_valid", 64'(out_valid0), 64'd0);
        chk("rst_out_data",  out_data0,       BUB);
        chk("rst_occ",       64'(occ0),       64'd0);
        chk("rst_occ_fw0",   64'(occ1),       64'd0);

        // streaming: A then B back to back with out_ready high
        rst = 1'b1; in_valid = 1'b1; in_data = A; out_ready = 1'b1;
        #1;
        chk("str_in_ready0", 64'(in_ready0), 64'd1);
        step();
        chk("str_A_valid", 64'(out_valid0), 64'd1);
        chk("str_A_data",  out_data0,       A);
        chk("str_A_ready", 64'(in_ready0),  64'd1);
        in_data = B;
        step();
        chk("str_B_data",  out_data0,      B);
        chk("str_B_occ",   64'(occ0),      64'd1);
        chk("str_B_ready", 64'(in_ready0), 64'd1);
        in_valid = 1'b0;
        step();
        chk("str_drain_valid", 64'(out_valid0), 64'd0);
        chk("str_drain_occ",   64'(occ0),       64'd0);
        chk("str_hold_data",   out_data0,       B);

        // backpressure: fill to FULL, then drain in order
        out_ready = 1'b0; in_valid = 1'b1; in_data = A;
        step();
        in_data = B;
        step();
        chk("bp_occ2",     64'(occ0),      64'd2);
        chk("bp_in_ready", 64'(in_ready0), 64'd0);
        chk("bp_hold_A",   out_data0,      A);
        in_valid = 1'b0;
        step();
        chk("bp_still_A",  out_data0,      A);
        out_ready = 1'b1;
        step();
        chk("bp_B_data",   out_data0,      B);
        chk("bp_B_ready",  64'(in_ready0), 64'd1);
        chk("bp_B_occ",    64'(occ0),      64'd1);
        step();
        chk("bp_empty",    64'(out_valid0), 64'd0);

        // flush while FULL
        out_ready = 1'b0; in_valid = 1'b1; in_data = A;
        step();
        in_data = B;
        step();
        chk("fl_full_occ", 64'(occ0), 64'd2);
        in_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_valid", 64'(out_valid0), 64'd0);
        chk("fl_data",  out_data0,       BUB);
        chk("fl_occ",   64'(occ0),       64'd0);
        chk("fl_ready", 64'(in_ready0),  64'd1);
        chk("fl_fw0_valid", 64'(out_valid1), 64'd0);

        // flush with coincident input C
        out_ready = 1'b0; in_valid = 1'b1; in_data = A;
        step();
        flush = 1'b1; in_data = C;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flc_fw1_valid", 64'(out_valid0), 64'd0);
        chk("flc_fw1_data",  out_data0,       BUB);
        chk("flc_fw0_valid", 64'(out_valid1), 64'd1);
        chk("flc_fw0_data",  out_data1,       C);
        chk("flc_fw0_occ",   64'(occ1),       64'd1);
        out_ready = 1'b1;
        step();
        chk("flc_fw0_drain", 64'(out_valid1), 64'd0);
        chk("flc_fw1_idle",  64'(out_valid0), 64'd0);

        // reset mid-operation from FULL
        out_ready = 1'b0; in_valid = 1'b1; in_data = A;
        step();
        in_data = B;
        step();
        chk("rm_full", 64'(occ0), 64'd2);
        rst = 1'b0; in_valid = 1'b0;
        step();
        chk("rm_occ",      64'(occ0),      64'd0);
        chk("rm_data",     out_data0,      BUB);
        chk("rm_in_ready", 64'(in_ready0), 64'd0);
        rst = 1'b1; out_ready = 1'b1;
        step();
        chk("rm_post_valid", 64'(out_valid0), 64'd0);
        chk("rm_post_ready", 64'(in_ready0),  64'd1);
        step();
        chk("rm_post_valid2", 64'(out_valid0), 64'd0);
        chk("rm_post_data",   out_data0,       BUB);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
Parametrised elastic pipeline register that generalises the fixed IF/ID register to any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
Replaces the global stall input with a valid/ready handshake and a 2-entry skid buffer, so that in_ready is registered and does not depend combinationally on out_ready.
Supports flush with a programmable bubble value; the default bubble is the RV32I NOP.
Gives 1-cycle latency and full throughput (1 transfer/cycle).

Parameters:
DATA_W, 64, payload width in bits (IF/ID: {pc[31:0], instr[31:0]}).
BUBBLE_VAL, {32'h0000_0000, 32'h0000_0013}, out_data value after reset or flush (pc=0, ADDI x0,x0,0).
FLUSH_WINS, 1, 1 = a flush coincident with in_valid discards the input; 0 = a flush clears older entries but captures the coincident input.

Ports:
clk        input   1       system clock, rising edge
rst        input   1       synchronous, active-low reset
flush      input   1       kill all held entries (branch/jump taken, from EX)
in_valid   input   1       upstream payload valid
in_ready   output  1       buffer can accept; registered
in_data    input   DATA_W  upstream payload
out_valid  output  1       downstream payload valid
out_ready  input   1       downstream accepts
out_data   output  DATA_W  payload to next stage
occupancy  output  2       number of held entries, 0..2 (debug/perf)

Behaviour:
- Fire definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register (drives out_data) and skid register. States are EMPTY (0 held), ONE (main valid), FULL (main and skid valid).
- Outputs: out_valid = (state != EMPTY); in_ready = (state != FULL) & rst. in_ready is 0 while rst is low.
- Reset (rst=0 at a rising edge):
  - state <= EMPTY.
  - main and skid data <= BUBBLE_VAL.
  - out_valid=0, occupancy=0.
- Transitions, evaluated when flush=0:
  - EMPTY: on in_fire, main <= in_data and go to ONE.
  - ONE, in_fire & out_fire: main <= in_data, stay in ONE.
  - ONE, in_fire & !out_fire: skid <= in_data, go to FULL.
  - ONE, !in_fire & out_fire: go to EMPTY; main data holds its last value.
  - ONE, neither fire: hold.
  - FULL: in_ready=0. On out_fire, main <= skid and go to ONE. Otherwise hold.
- Flush, from any state:
  - FLUSH_WINS=1: next state is EMPTY; main <= BUBBLE_VAL; skid is invalidated; the coincident input is dropped even if in_fire.
  - FLUSH_WINS=0: the coincident in_fire payload is loaded into main and next state is ONE; otherwise behaviour is as for FLUSH_WINS=1.
- Priority: rst > flush > handshake.
- Ordering: payloads exit in acceptance order. No duplication and no loss except by flush.
- out_data is stable while out_valid=1 and out_ready=0. A held payload must not change until out_fire.
- Latency: in_fire at cycle N gives out_valid at N+1 when the buffer was EMPTY, or when it was ONE with a coincident out_fire.
- occupancy: 0 in EMPTY, 1 in ONE, 2 in FULL; updates with state.
- Flush while FULL: both entries are dropped and nothing is transferred downstream. in_ready returns to 1 the next cycle.
- Legacy stall mapping: out_ready = !stall reproduces the previous hold behaviour.

Decomposition:
- Shared package pipe_pkg holds:
  - RV_NOP = 32'h0000_0013.
  - The enum pipe_occ_e {EMPTY, ONE, FULL} (2-bit).
  - The typedef if_id_t packed struct {pc, instr}; its width sets DATA_W for the IF/ID instance.
- No sub-module. It is a single module; the skid entry is too small to split out.

Test Plan:
- Reset: hold rst=0 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, out_data=64'h0000_0000_0000_0013, occupancy=0.
- Streaming: out_ready=1, send A=0x0000_0004_0000_0093 then B=0x0000_0008_0010_0113 on consecutive cycles -> A appears at N+1 and B at N+2, in_ready stays 1 throughout.
- Backpressure: out_ready=0, send A then B -> occupancy=2 and in_ready=0 the cycle after B; raise out_ready -> A then B are delivered in order and in_ready=1 after A drains.
- Flush in FULL: with A and B held, flush=1 -> next cycle out_valid=0, out_data=BUBBLE_VAL, occupancy=0, no out_fire observed.
- Flush with a coincident input C:
  - FLUSH_WINS=1 -> C is dropped and out_valid=0.
  - FLUSH_WINS=0 -> out_valid=1 and out_data=C next cycle.
- Reset mid-operation: state FULL, then rst=0 for one cycle -> EMPTY and BUBBLE_VAL; the old payloads never emerge after rst returns high.
